bsg_async_ptr_gray_rd: RTL and testbench
========================================

# bsg_async_ptr_gray_rd

Read-side pointer controller for the gray-coded async FIFO. It runs entirely in the read clock domain and consumes the write pointer after it has been gray-encoded and double-synchronized into this domain. It converts that pointer to binary, owns the binary and gray read pointers, and generates occupancy and valid to the consumer. Its registered gray read pointer is the value the write domain synchronizes back for its full check.

## Interface
- lg_size_p, default 4: log2 of FIFO depth; pointers are lg_size_p+1 bits, including the wrap bit.
- clk_i  input  1  read-domain clock; all state on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- w_ptr_gray_rsync_i  input  lg_size_p+1  write pointer, gray-coded, already synchronized to clk_i.
- deq_i  input  1  consumer dequeue request; acted on only when valid_o=1.
- valid_o  output  1  FIFO non-empty (registered-state derived).
- r_addr_o  output  lg_size_p  RAM read address = r_ptr_binary_o[lg_size_p-1:0].
- r_ptr_binary_o  output  lg_size_p+1  binary read pointer.
- r_ptr_gray_r_o  output  lg_size_p+1  registered gray read pointer for the write domain.
- count_o  output  lg_size_p+1  occupancy, 0..2^lg_size_p.
- error_o  output  1  sticky protocol/consistency error (see Configuration).

## Operation
- w_bin_r register: gray-to-binary of w_ptr_gray_rsync_i, loaded every cycle; bin[msb]=gray[msb], bin[i]=bin[i+1]^gray[i].
- r_ptr_r register: binary read pointer. r_gray_r register: r_ptr ^ (r_ptr>>1), loaded on the same edge with the gray of the next r_ptr_r value, so it is never a combinational output.
- valid_o = (w_bin_r != r_ptr_r).
- count_o = w_bin_r - r_ptr_r, modulo 2^(lg_size_p+1).
- deq_fire = deq_i & valid_o. On deq_fire, r_ptr_r <= r_ptr_r+1 (wraps 2^(lg_size_p+1)-1 -> 0) and r_gray_r <= gray(r_ptr_r+1).
- deq_i while valid_o=0: pointers are unchanged. The request is ignored; error is flagged only when the macro is enabled.
- Full FIFO: count_o = 2^lg_size_p and valid_o=1. MSBs differ and the low bits are equal.
- Write advance and deq_fire in the same cycle: both apply. count_o reflects the net change the following cycle.
- Synced pointer jumping by more than 1 gray step (fast write clock): the conversion handles any jump. count_o follows it.
- Reset (asynchronous, any cycle, including mid-dequeue): w_bin_r, r_ptr_r, r_gray_r and error_o = 0. valid_o=0, count_o=0, r_addr_o=0. The first update happens on the first posedge after reset deasserts.

## Timing
- w_ptr_gray_rsync_i -> valid_o/count_o: 1 cycle (through w_bin_r).
- deq_fire at edge n -> r_ptr_binary_o, r_addr_o and r_ptr_gray_r_o updated after edge n. count_o drops after edge n.
- RAM read data for r_addr_o is the consumer's concern. This block adds no data latency.
- Every output is a function of registers only. There is no input-to-output combinational path except through deq_i gating, which affects next state only.

## Configuration
- Macro BSG_ASYNC_PTR_GRAY_RD_CHECK_EN.
- Defined: error_o sets (sticky until reset) when either condition occurs:
  - deq_i=1 while valid_o=0;
  - computed count_o > 2^lg_size_p, meaning the synchronized write pointer is corrupt or has overrun.
- Defined: on either condition, a simulation-only $error is printed with the cycle's pointer values.
- Not defined: error_o is tied to 0 and no check logic or $error is emitted. All other behaviour is identical.

## Test plan
All scenarios use lg_size_p=4.
- Reset: hold reset_i, then drive w_ptr_gray_rsync_i=5'b00110 -> all outputs 0. After release, 1 cycle later valid_o=1 and count_o=4 (gray 00110 = bin 4).
- Drain: w_gray = gray(3) = 00010, then hold deq_i=1 for 5 cycles -> r_ptr_binary_o steps 0,1,2,3 and stops. r_ptr_gray_r_o steps 00000,00001,00011,00010. valid_o falls after the third deq_fire. With CHECK_EN, error_o=1 after the 4th edge.
- Full and wrap: r_ptr at 28, w_gray = gray(12) = 01010 -> count_o=16, valid_o=1. Dequeue 16 times -> r_ptr wraps 31->0 and ends at 12, r_addr_o ends at 12, count_o=0.
- Simultaneous: count_o=2, then advance w_gray by 1 and assert deq_i in the same cycle -> count_o stays 2 after 1 cycle.
- Async reset mid-operation: assert reset_i between edges while count_o=5 and deq_i=1 -> outputs go to 0 immediately, with no clock edge needed.
- Corruption: with CHECK_EN, force w_gray such that count_o=20 -> error_o=1 and stays 1 until reset. Without the macro, error_o stays 0.

Source files
------------

// File: rtl/bsg_async_ptr_gray_rd.sv
// Read-side pointer controller for a gray-coded asynchronous FIFO.
// Converts the synchronized gray write pointer to binary, owns the binary and
// gray read pointers, and derives valid/occupancy for the consumer.
// Optional checking is enabled by defining BSG_ASYNC_PTR_GRAY_RD_CHECK_EN:
// error_o then flags dequeue-while-empty and impossible occupancy (sticky).
module bsg_async_ptr_gray_rd
  #(parameter int lg_size_p = 4)
   (input  logic                 clk_i
   ,input  logic                 reset_i
   ,input  logic [lg_size_p:0]   w_ptr_gray_rsync_i
   ,input  logic                 deq_i
   ,output logic                 valid_o
   ,output logic [lg_size_p-1:0] r_addr_o
   ,output logic [lg_size_p:0]   r_ptr_binary_o
   ,output logic [lg_size_p:0]   r_ptr_gray_r_o
   ,output logic [lg_size_p:0]   count_o
   ,output logic                 error_o
   );

   localparam int ptr_w_lp = lg_size_p + 1;
   localparam logic [ptr_w_lp-1:0] depth_lp = ptr_w_lp'(1) << lg_size_p;

   function automatic logic [ptr_w_lp-1:0] gray2bin(input logic [ptr_w_lp-1:0] g);
      logic [ptr_w_lp-1:0] b;
      b = '0;
      b[ptr_w_lp-1] = g[ptr_w_lp-1];
      for (int i = ptr_w_lp-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [ptr_w_lp-1:0] bin2gray(input logic [ptr_w_lp-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [ptr_w_lp-1:0] w_bin_q, w_bin_d;
   logic [ptr_w_lp-1:0] r_ptr_q, r_ptr_d;
   logic [ptr_w_lp-1:0] r_gray_q, r_gray_d;
   logic [ptr_w_lp-1:0] count;
   logic                valid;
   logic                deq_fire;

   // Occupancy and valid come from registered pointers only.
   assign valid    = (w_bin_q != r_ptr_q);
   assign count    = w_bin_q - r_ptr_q;
   assign deq_fire = deq_i & valid;

   // Next-state: write pointer converted every cycle, read pointer advances on dequeue.
   always_comb begin
      w_bin_d  = gray2bin(w_ptr_gray_rsync_i);
      r_ptr_d  = r_ptr_q;
      if (deq_fire) begin
         r_ptr_d = r_ptr_q + 1'b1;
      end
      // Gray of the next pointer is registered so the write domain never sees glitches.
      r_gray_d = bin2gray(r_ptr_d);
   end

   // Pointer registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         w_bin_q  <= '0;
         r_ptr_q  <= '0;
         r_gray_q <= '0;
      end else begin
         w_bin_q  <= w_bin_d;
         r_ptr_q  <= r_ptr_d;
         r_gray_q <= r_gray_d;
      end
   end

   assign valid_o        = valid;
   assign count_o        = count;
   assign r_ptr_binary_o = r_ptr_q;
   assign r_addr_o       = r_ptr_q[lg_size_p-1:0];
   assign r_ptr_gray_r_o = r_gray_q;

`ifdef BSG_ASYNC_PTR_GRAY_RD_CHECK_EN
   logic error_q, error_d;
   logic deq_underflow;
   logic count_overrun;

   assign deq_underflow = deq_i & ~valid;
   assign count_overrun = (count > depth_lp);
   assign error_d       = error_q | deq_underflow | count_overrun;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

`ifndef SYNTHESIS
   // Report the offending pointer values in simulation.
   always_ff @(posedge clk_i) begin
      if (!reset_i && (deq_underflow || count_overrun)) begin
         $error("bsg_async_ptr_gray_rd: underflow=%0b overrun=%0b w_bin=%0d r_ptr=%0d count=%0d",
                deq_underflow, count_overrun, w_bin_q, r_ptr_q, count);
      end
   end
`endif

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_async_ptr_gray_rd.sv
module tb_bsg_async_ptr_gray_rd;

   localparam int LG = 4;
`ifdef BSG_ASYNC_PTR_GRAY_RD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_i;
   logic [LG:0]   w_ptr_gray_rsync_i;
   logic          deq_i;
   logic          valid_o;
   logic [LG-1:0] r_addr_o;
   logic [LG:0]   r_ptr_binary_o;
   logic [LG:0]   r_ptr_gray_r_o;
   logic [LG:0]   count_o;
   logic          error_o;

   int total  = 0;
   int passed = 0;

   bsg_async_ptr_gray_rd #(.lg_size_p(LG)) dut
     (.clk_i              (clk)
     ,.reset_i            (reset_i)
     ,.w_ptr_gray_rsync_i (w_ptr_gray_rsync_i)
     ,.deq_i              (deq_i)
     ,.valid_o            (valid_o)
     ,.r_addr_o           (r_addr_o)
     ,.r_ptr_binary_o     (r_ptr_binary_o)
     ,.r_ptr_gray_r_o     (r_ptr_gray_r_o)
     ,.count_o            (count_o)
     ,.error_o            (error_o)
     );

   always #5 clk = ~clk;

   typedef struct {
      logic [LG:0]   w_gray;
      logic          deq;
      logic          e_valid;
      logic [LG:0]   e_count;
      logic [LG:0]   e_rptr;
      logic [LG:0]   e_rgray;
      logic [LG-1:0] e_addr;
      logic          e_err;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [LG:0] gray(input logic [LG:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Advance one active edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [LG:0] c,
                          input logic [LG:0] rp, input logic [LG:0] rg, input logic e);
      chk({tag, ".valid"}, 32'(valid_o), 32'(v));
      chk({tag, ".count"}, 32'(count_o), 32'(c));
      chk({tag, ".rptr"},  32'(r_ptr_binary_o), 32'(rp));
      chk({tag, ".rgray"}, 32'(r_ptr_gray_r_o), 32'(rg));
      chk({tag, ".addr"},  32'(r_addr_o), 32'(rp[LG-1:0]));
      chk({tag, ".err"},   32'(error_o), 32'(e));
   endtask

   task automatic do_reset();
      deq_i = 1'b0;
      w_ptr_gray_rsync_i = '0;
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   initial begin
      // Drain vectors: w = 3, r starts at 0, deq held for 5 cycles.
      vecs[0] = '{5'b00010, 1'b1, 1'b1, 5'd2, 5'd1, 5'b00001, 4'd1, 1'b0};
      vecs[1] = '{5'b00010, 1'b1, 1'b1, 5'd1, 5'd2, 5'b00011, 4'd2, 1'b0};
      vecs[2] = '{5'b00010, 1'b1, 1'b0, 5'd0, 5'd3, 5'b00010, 4'd3, 1'b0};
      vecs[3] = '{5'b00010, 1'b1, 1'b0, 5'd0, 5'd3, 5'b00010, 4'd3, CHK};
      vecs[4] = '{5'b00010, 1'b1, 1'b0, 5'd0, 5'd3, 5'b00010, 4'd3, CHK};

      // Reset holds everything at zero even with a nonzero write pointer.
      reset_i = 1'b1;
      deq_i = 1'b0;
      w_ptr_gray_rsync_i = 5'b00110;
      tick();
      tick();
      chk_all("rst", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      reset_i = 1'b0;
      tick();
      chk("rst_rel.valid", 32'(valid_o), 32'd1);
      chk("rst_rel.count", 32'(count_o), 32'd4);

      // Drain, table driven.
      do_reset();
      w_ptr_gray_rsync_i = 5'b00010;
      tick();
      chk("drain0.count", 32'(count_o), 32'd3);
      for (int i = 0; i < 5; i++) begin
         w_ptr_gray_rsync_i = vecs[i].w_gray;
         deq_i = vecs[i].deq;
         tick();
         chk($sformatf("drain%0d.valid", i+1), 32'(valid_o), 32'(vecs[i].e_valid));
         chk($sformatf("drain%0d.count", i+1), 32'(count_o), 32'(vecs[i].e_count));
         chk($sformatf("drain%0d.rptr", i+1), 32'(r_ptr_binary_o), 32'(vecs[i].e_rptr));
         chk($sformatf("drain%0d.rgray", i+1), 32'(r_ptr_gray_r_o), 32'(vecs[i].e_rgray));
         chk($sformatf("drain%0d.addr", i+1), 32'(r_addr_o), 32'(vecs[i].e_addr));
         chk($sformatf("drain%0d.err", i+1), 32'(error_o), 32'(vecs[i].e_err));
      end

      // Walk the read pointer to 28 while keeping occupancy at 1.
      do_reset();
      w_ptr_gray_rsync_i = gray(5'd1);
      tick();
      for (int i = 2; i <= 28; i++) begin
         w_ptr_gray_rsync_i = gray(5'(i));
         deq_i = 1'b1;
         tick();
      end
      tick();
      deq_i = 1'b0;
      chk_all("walk", 1'b0, 5'd0, 5'd28, 5'b10010, 1'b0);

      // Full: r=28, w=12 -> 16 entries.
      w_ptr_gray_rsync_i = 5'b01010;
      tick();
      chk_all("full", 1'b1, 5'd16, 5'd28, 5'b10010, 1'b0);
      deq_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk_all("wrap", 1'b1, 5'd12, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < 12; i++) tick();
      deq_i = 1'b0;
      chk_all("empty12", 1'b0, 5'd0, 5'd12, 5'b01010, 1'b0);

      // Simultaneous write advance and dequeue keeps occupancy.
      w_ptr_gray_rsync_i = gray(5'd14);
      tick();
      chk("sim0.count", 32'(count_o), 32'd2);
      w_ptr_gray_rsync_i = gray(5'd15);
      deq_i = 1'b1;
      tick();
      deq_i = 1'b0;
      chk_all("sim1", 1'b1, 5'd2, 5'd13, 5'b01011, 1'b0);

      // Multi-step jump of the synchronized pointer, then async reset mid-operation.
      w_ptr_gray_rsync_i = gray(5'd18);
      tick();
      chk("jump.count", 32'(count_o), 32'd5);
      deq_i = 1'b1;
      #2;
      reset_i = 1'b1;
      #1;
      chk_all("areset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      deq_i = 1'b0;
      w_ptr_gray_rsync_i = '0;
      tick();
      reset_i = 1'b0;
      tick();
      chk_all("post_areset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

      // Corrupt pointer: occupancy 20 cannot happen in a 16-deep FIFO.
      w_ptr_gray_rsync_i = gray(5'd20);
      tick();
      chk("corrupt.count", 32'(count_o), 32'd20);
      tick();
      chk("corrupt.err", 32'(error_o), 32'(CHK));
      w_ptr_gray_rsync_i = '0;
      tick();
      tick();
      chk("corrupt.sticky", 32'(error_o), 32'(CHK));
      chk("corrupt.count0", 32'(count_o), 32'd0);
      do_reset();
      #1;
      chk("corrupt.cleared", 32'(error_o), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
